core_idu_pipe: RTL and testbench
================================

CORE_IDU_PIPE -- requirements
Module: core_idu_pipe

Interface
REQ-001 Parameter XLEN, default 64, operand/immediate width; legal values 32 or 64.
REQ-002 Parameter PC_W, default 64, PC width.
REQ-003 Parameter RF_IDX_W, default 5, register index width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  fetch offers instruction; in_ready  out  1  decode slot accepts.
REQ-007 in_pc  in  PC_W; in_snpc  in  PC_W; in_instr  in  32.
REQ-008 rf_rs1_idx, rf_rs2_idx  out  RF_IDX_W  combinational register-file read addresses.
REQ-009 rf_rs1_data, rf_rs2_data  in  XLEN  same-cycle register-file read data.
REQ-010 ex_rd_wen, ex_is_load  in  1; ex_rd_idx  in  RF_IDX_W  instruction currently in EX.
REQ-011 mem_rd_wen  in  1; mem_rd_idx  in  RF_IDX_W; mem_rd_data  in  XLEN  forwarding source.
REQ-012 flush  in  1  kill all instructions held in this block.
REQ-013 out_valid  out  1; out_ready  in  1  handshake to EX.
REQ-014 out_pc, out_snpc, out_target  out  PC_W; out_instr  out  32; out_imm, out_rs1_data, out_rs2_data  out  XLEN.
REQ-015 out_rd_idx  out  RF_IDX_W; out_funct3  out  3; out_funct7  out  7; out_br_flags  out  3  {eq, lt, ltu}.
REQ-016 stall_cnt  out  32  load-use stall cycle counter.

Function
REQ-017 Two registered slots SHALL exist: D (IF/ID, holds pc/snpc/instr + d_valid) and E (ID/EX, drives all out_* + out_valid).
REQ-018 rf_rs1_idx = D.instr[19:15], rf_rs2_idx = D.instr[24:20], combinational from D.
REQ-019 Immediate SHALL decode by opcode: I (LOAD, OP-IMM, OP-IMM-32, JALR), S, B, U, J; other opcodes -> 0; sign-extended to XLEN.
REQ-020 rs1 SHALL count as used unless opcode is LUI, AUIPC or JAL; rs2 used only for BRANCH, STORE, OP, OP-32.
REQ-021 Operand select: index 0 -> 0; else mem_rd_wen && mem_rd_idx == index -> mem_rd_data; else rf data.
REQ-022 Load-use hazard = d_valid && ex_is_load && ex_rd_wen && ex_rd_idx != 0 && ex_rd_idx matches a used rs.
REQ-023 D advances to E when d_valid && !hazard && (!out_valid || out_ready).
REQ-024 in_ready = !d_valid || D advances; D captures input when in_valid && in_ready.
REQ-025 When E is consumed (out_valid && out_ready) and D does not advance, out_valid SHALL drop to 0 next cycle (bubble); E data is don't-care.
REQ-026 E SHALL hold all outputs stable while out_valid && !out_ready.
REQ-027 out_target = (JALR ? (fwd_rs1 + imm) with bit 0 cleared : D.pc + imm), truncated to PC_W.
REQ-028 out_br_flags from forwarded operands: eq = equal, lt = signed less-than, ltu = unsigned less-than, XLEN-wide.
REQ-029 out_rd_idx = instr[11:7], funct3 = instr[14:12], funct7 = instr[31:25], registered with E.
REQ-030 flush SHALL clear d_valid and out_valid at the next edge, overriding capture and advance; in_ready = 0 during flush.
REQ-031 stall_cnt SHALL increment each cycle hazard is asserted, saturating at 0xFFFFFFFF; not cleared by flush.
REQ-032 Throughput one instruction/cycle with no hazard and out_ready=1; in-to-out latency 2 edges.

Reset
REQ-033 On rst: d_valid=0, out_valid=0, stall_cnt=0, all E data registers 0; in_ready=1 after reset deasserts.
REQ-034 rst asserted mid-stall or mid-backpressure SHALL discard both slots immediately, no output handshake emitted.

Verification
REQ-035 Stream ADDI x1,x0,5 then ADD x2,x1,x1, out_ready=1 -> out_valid on edges 2 and 3, imm=5 then 0, no stall.
REQ-036 ex_is_load, ex_rd_idx=3 with D=ADD x4,x3,x5 -> one bubble, D held, in_ready=0, stall_cnt=1.
REQ-037 mem_rd_idx=6, mem_rd_data=0xFFFF_FFFF_FFFF_FFFF, D=BEQ x6,x0,-8, pc=0x100 -> out_br_flags=3'b010, out_target=0xF8.
REQ-038 out_ready=0 for 3 cycles with D and E full -> outputs stable, in_ready=0, no instruction lost or duplicated.
REQ-039 flush with in_valid=1 and both slots full -> next cycle out_valid=0, d_valid=0, offered instruction dropped.
REQ-040 JALR x1,x7,3 with x7=0x2000 -> out_target=0x2002; XLEN=32 build repeats REQ-035..037 with 32-bit values.

Source files
------------

// File: rtl/core_idu_pipe_if.sv
// core_idu_pipe_if: fetch, register-file, hazard, forwarding and EX-side signals of the decode pipe
interface core_idu_pipe_if #(
    parameter int XLEN     = 64,
    parameter int PC_W     = 64,
    parameter int RF_IDX_W = 5
);
    logic                in_valid, in_ready;
    logic [PC_W-1:0]     in_pc, in_snpc;
    logic [31:0]         in_instr;
    logic [RF_IDX_W-1:0] rf_rs1_idx, rf_rs2_idx;
    logic [XLEN-1:0]     rf_rs1_data, rf_rs2_data;
    logic                ex_rd_wen, ex_is_load;
    logic [RF_IDX_W-1:0] ex_rd_idx;
    logic                mem_rd_wen;
    logic [RF_IDX_W-1:0] mem_rd_idx;
    logic [XLEN-1:0]     mem_rd_data;
    logic                flush;
    logic                out_valid, out_ready;
    logic [PC_W-1:0]     out_pc, out_snpc, out_target;
    logic [31:0]         out_instr;
    logic [XLEN-1:0]     out_imm, out_rs1_data, out_rs2_data;
    logic [RF_IDX_W-1:0] out_rd_idx;
    logic [2:0]          out_funct3;
    logic [6:0]          out_funct7;
    logic [2:0]          out_br_flags;
    logic [31:0]         stall_cnt;

    modport slave (
        input  in_valid, in_pc, in_snpc, in_instr, rf_rs1_data, rf_rs2_data,
               ex_rd_wen, ex_is_load, ex_rd_idx, mem_rd_wen, mem_rd_idx, mem_rd_data,
               flush, out_ready,
        output in_ready, rf_rs1_idx, rf_rs2_idx, out_valid, out_pc, out_snpc, out_target,
               out_instr, out_imm, out_rs1_data, out_rs2_data, out_rd_idx, out_funct3,
               out_funct7, out_br_flags, stall_cnt
    );

    modport master (
        output in_valid, in_pc, in_snpc, in_instr, rf_rs1_data, rf_rs2_data,
               ex_rd_wen, ex_is_load, ex_rd_idx, mem_rd_wen, mem_rd_idx, mem_rd_data,
               flush, out_ready,
        input  in_ready, rf_rs1_idx, rf_rs2_idx, out_valid, out_pc, out_snpc, out_target,
               out_instr, out_imm, out_rs1_data, out_rs2_data, out_rd_idx, out_funct3,
               out_funct7, out_br_flags, stall_cnt
    );
endinterface

// File: rtl/core_idu_pipe.sv
// core_idu_pipe: two-slot RISC-V decode stage with immediate decode, forwarding, load-use stall and branch flags
module core_idu_pipe #(
    parameter int XLEN     = 64,
    parameter int PC_W     = 64,
    parameter int RF_IDX_W = 5
) (
    input logic           clk,
    input logic           rst,
    core_idu_pipe_if.slave bus
);
    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_IMM = 7'b0010011, OP_IMM32 = 7'b0011011,
                           OP_JALR = 7'b1100111, OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011,
                           OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_OP = 7'b0110011, OP_OP32 = 7'b0111011;

    logic            d_valid;
    logic [PC_W-1:0] d_pc, d_snpc, target;
    logic [31:0]     d_instr, imm32;
    logic [6:0]      op;
    logic [XLEN-1:0] imm, rs1_val, rs2_val, jsum;
    logic            is_i, is_u, use_rs1, use_rs2, hazard, advance;

    assign op             = d_instr[6:0];
    assign bus.rf_rs1_idx = RF_IDX_W'(d_instr[19:15]);
    assign bus.rf_rs2_idx = RF_IDX_W'(d_instr[24:20]);
    assign is_i           = op == OP_LOAD || op == OP_IMM || op == OP_IMM32 || op == OP_JALR;
    assign is_u           = op == OP_LUI || op == OP_AUIPC;
    assign use_rs1        = !(is_u || op == OP_JAL);
    assign use_rs2        = op == OP_BRANCH || op == OP_STORE || op == OP_OP || op == OP_OP32;

    always_comb begin
        imm32 = is_i             ? {{20{d_instr[31]}}, d_instr[31:20]} :
                op == OP_STORE   ? {{20{d_instr[31]}}, d_instr[31:25], d_instr[11:7]} :
                op == OP_BRANCH  ? {{19{d_instr[31]}}, d_instr[31], d_instr[7], d_instr[30:25], d_instr[11:8], 1'b0} :
                is_u             ? {d_instr[31:12], 12'b0} :
                op == OP_JAL     ? {{11{d_instr[31]}}, d_instr[31], d_instr[19:12], d_instr[20], d_instr[30:21], 1'b0} :
                                   32'b0;
        imm = XLEN'($signed(imm32));
    end

    // MEM-stage result wins over the register file; x0 always reads zero
    assign rs1_val = bus.rf_rs1_idx == '0 ? '0 :
                     (bus.mem_rd_wen && bus.mem_rd_idx == bus.rf_rs1_idx) ? bus.mem_rd_data : bus.rf_rs1_data;
    assign rs2_val = bus.rf_rs2_idx == '0 ? '0 :
                     (bus.mem_rd_wen && bus.mem_rd_idx == bus.rf_rs2_idx) ? bus.mem_rd_data : bus.rf_rs2_data;

    assign hazard  = d_valid && bus.ex_is_load && bus.ex_rd_wen && bus.ex_rd_idx != '0 &&
                     ((use_rs1 && bus.ex_rd_idx == bus.rf_rs1_idx) || (use_rs2 && bus.ex_rd_idx == bus.rf_rs2_idx));
    assign advance      = d_valid && !hazard && (!bus.out_valid || bus.out_ready);
    assign bus.in_ready = !bus.flush && (!d_valid || advance);

    assign jsum   = rs1_val + imm;
    assign target = op == OP_JALR ? PC_W'($signed({jsum[XLEN-1:1], 1'b0})) : d_pc + PC_W'($signed(imm));

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            d_valid <= 1'b0;
            d_pc    <= '0;
            d_snpc  <= '0;
            d_instr <= '0;
        end else if (bus.flush) begin
            d_valid <= 1'b0;
        end else if (bus.in_valid && bus.in_ready) begin
            d_valid <= 1'b1;
            d_pc    <= bus.in_pc;
            d_snpc  <= bus.in_snpc;
            d_instr <= bus.in_instr;
        end else if (advance) begin
            d_valid <= 1'b0;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bus.out_valid    <= 1'b0;
            bus.out_pc       <= '0;
            bus.out_snpc     <= '0;
            bus.out_target   <= '0;
            bus.out_instr    <= '0;
            bus.out_imm      <= '0;
            bus.out_rs1_data <= '0;
            bus.out_rs2_data <= '0;
            bus.out_rd_idx   <= '0;
            bus.out_funct3   <= '0;
            bus.out_funct7   <= '0;
            bus.out_br_flags <= '0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (advance) begin
            bus.out_valid    <= 1'b1;
            bus.out_pc       <= d_pc;
            bus.out_snpc     <= d_snpc;
            bus.out_target   <= target;
            bus.out_instr    <= d_instr;
            bus.out_imm      <= imm;
            bus.out_rs1_data <= rs1_val;
            bus.out_rs2_data <= rs2_val;
            bus.out_rd_idx   <= RF_IDX_W'(d_instr[11:7]);
            bus.out_funct3   <= d_instr[14:12];
            bus.out_funct7   <= d_instr[31:25];
            bus.out_br_flags <= {rs1_val == rs2_val, $signed(rs1_val) < $signed(rs2_val), rs1_val < rs2_val};
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) bus.stall_cnt <= '0;
        else if (hazard && bus.stall_cnt != '1) bus.stall_cnt <= bus.stall_cnt + 32'd1;
endmodule

// File: tb/tb_core_idu_pipe.sv
// tb_core_idu_pipe: directed bench for core_idu_pipe; expected EX-side transactions are queued at issue and checked on handshake
module tb_core_idu_pipe;
    localparam logic [31:0] I_ADDI   = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] I_ADD21  = 32'h00108133;  // add  x2,x1,x1
    localparam logic [31:0] I_ADD435 = 32'h00518233;  // add  x4,x3,x5
    localparam logic [31:0] I_BEQ    = 32'hFE030CE3;  // beq  x6,x0,-8
    localparam logic [31:0] I_JALR   = 32'h003380E7;  // jalr x1,x7,3

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] imm, target, rs1, rs2;
        logic [2:0]  flags;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    core_idu_pipe_if #(.XLEN(64), .PC_W(64), .RF_IDX_W(5)) bus ();
    core_idu_pipe #(.XLEN(64), .PC_W(64), .RF_IDX_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [63:0] regs [32];
    exp_t        sb [$];
    exp_t        e;
    int          n_chk = 0;
    int          n_fail = 0;

    assign bus.rf_rs1_data = regs[bus.rf_rs1_idx];
    assign bus.rf_rs2_data = regs[bus.rf_rs2_idx];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [63:0] pc, input logic [31:0] instr, input logic [63:0] imm,
                        input logic [63:0] target, input logic [63:0] rs1, input logic [63:0] rs2,
                        input logic [2:0] flags);
        sb.push_back('{pc, instr, imm, target, rs1, rs2, flags});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [63:0] pc, input logic [31:0] instr);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_snpc  = pc + 64'd4;
        bus.in_instr = instr;
    endtask

    always @(negedge clk)
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 64'(bus.out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("out_pc", bus.out_pc, e.pc);
                chk("out_snpc", bus.out_snpc, e.pc + 64'd4);
                chk("out_instr", 64'(bus.out_instr), 64'(e.instr));
                chk("out_imm", bus.out_imm, e.imm);
                chk("out_target", bus.out_target, e.target);
                chk("out_rs1_data", bus.out_rs1_data, e.rs1);
                chk("out_rs2_data", bus.out_rs2_data, e.rs2);
                chk("out_br_flags", 64'(bus.out_br_flags), 64'(e.flags));
                chk("out_rd_idx", 64'(bus.out_rd_idx), 64'(e.instr[11:7]));
                chk("out_funct3", 64'(bus.out_funct3), 64'(e.instr[14:12]));
            end
        end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 64'h1000 + 64'(i);
        regs[0] = 64'd0;
        regs[7] = 64'h2000;
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_snpc = '0; bus.in_instr = '0;
        bus.ex_rd_wen = 1'b0; bus.ex_is_load = 1'b0; bus.ex_rd_idx = '0;
        bus.mem_rd_wen = 1'b0; bus.mem_rd_idx = '0; bus.mem_rd_data = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        step(); step();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
        chk("rst_out_imm", bus.out_imm, 64'd0);
        chk("rst_out_pc", bus.out_pc, 64'd0);
        rst = 1'b0;
        #1 chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // back-to-back ADDI then ADD: outputs after edges 2 and 3
        offer(64'h1000, I_ADDI);
        push(64'h1000, I_ADDI, 64'd5, 64'h1005, 64'd0, 64'h1005, 3'b011);
        step();
        chk("e1_out_valid", 64'(bus.out_valid), 64'd0);
        offer(64'h1004, I_ADD21);
        push(64'h1004, I_ADD21, 64'd0, 64'h1004, 64'h1001, 64'h1001, 3'b100);
        step();
        chk("e2_out_valid", 64'(bus.out_valid), 64'd1);
        chk("e2_imm", bus.out_imm, 64'd5);
        bus.in_valid = 1'b0;
        step();
        chk("e3_out_valid", 64'(bus.out_valid), 64'd1);
        chk("e3_imm", bus.out_imm, 64'd0);
        step();
        chk("e4_bubble", 64'(bus.out_valid), 64'd0);
        chk("stream_stall_cnt", 64'(bus.stall_cnt), 64'd0);

        // load-use on rs1
        offer(64'h2000, I_ADD435);
        push(64'h2000, I_ADD435, 64'd0, 64'h2000, 64'h1003, 64'h1005, 3'b011);
        step();
        offer(64'h2004, I_ADDI);
        bus.ex_is_load = 1'b1; bus.ex_rd_wen = 1'b1; bus.ex_rd_idx = 5'd3;
        #1 chk("hz_in_ready", 64'(bus.in_ready), 64'd0);
        step();
        chk("hz_bubble", 64'(bus.out_valid), 64'd0);
        chk("hz_stall_cnt", 64'(bus.stall_cnt), 64'd1);
        chk("hz_in_ready_held", 64'(bus.in_ready), 64'd0);
        bus.ex_is_load = 1'b0; bus.ex_rd_wen = 1'b0; bus.ex_rd_idx = '0;
        #1 chk("hz_release_in_ready", 64'(bus.in_ready), 64'd1);
        push(64'h2004, I_ADDI, 64'd5, 64'h2009, 64'd0, 64'h1005, 3'b011);
        step();
        chk("hz_out_valid", 64'(bus.out_valid), 64'd1);
        chk("hz_out_pc", bus.out_pc, 64'h2000);
        bus.in_valid = 1'b0;
        step(); step();
        chk("hz_stall_after", 64'(bus.stall_cnt), 64'd1);

        // forwarded all-ones into BEQ
        bus.mem_rd_wen = 1'b1; bus.mem_rd_idx = 5'd6; bus.mem_rd_data = '1;
        offer(64'h100, I_BEQ);
        push(64'h100, I_BEQ, 64'hFFFF_FFFF_FFFF_FFF8, 64'hF8, '1, 64'd0, 3'b010);
        step();
        bus.in_valid = 1'b0;
        step();
        chk("beq_flags", 64'(bus.out_br_flags), 64'd2);
        chk("beq_target", bus.out_target, 64'hF8);
        bus.mem_rd_wen = 1'b0;
        step();

        // JALR target clears bit 0
        offer(64'h300, I_JALR);
        push(64'h300, I_JALR, 64'd3, 64'h2002, 64'h2000, 64'h1003, 3'b000);
        step();
        bus.in_valid = 1'b0;
        step();
        chk("jalr_target", bus.out_target, 64'h2002);
        step();

        // three cycles of backpressure with both slots full
        bus.out_ready = 1'b0;
        offer(64'h400, I_ADDI);
        push(64'h400, I_ADDI, 64'd5, 64'h405, 64'd0, 64'h1005, 3'b011);
        step();
        offer(64'h404, I_ADD21);
        push(64'h404, I_ADD21, 64'd0, 64'h404, 64'h1001, 64'h1001, 3'b100);
        step();
        offer(64'h408, I_ADD435);
        push(64'h408, I_ADD435, 64'd0, 64'h408, 64'h1003, 64'h1005, 3'b011);
        #1 chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_out_pc", bus.out_pc, 64'h400);
            chk("bp_out_instr", 64'(bus.out_instr), 64'(I_ADDI));
            chk("bp_in_ready_held", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step(); step();
        chk("bp_drained", 64'(bus.out_valid), 64'd0);

        // flush with both slots full and a third instruction offered
        bus.out_ready = 1'b0;
        offer(64'h500, I_ADDI);
        step();
        offer(64'h504, I_ADD21);
        step();
        offer(64'h508, I_ADD435);
        bus.flush = 1'b1;
        #1 chk("fl_in_ready", 64'(bus.in_ready), 64'd0);
        step();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        #1 chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_d_empty", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        step();
        chk("fl_no_out1", 64'(bus.out_valid), 64'd0);
        step();
        chk("fl_no_out2", 64'(bus.out_valid), 64'd0);
        chk("fl_stall_kept", 64'(bus.stall_cnt), 64'd1);

        // reset during a stall with EX backpressured, hazard on rs2
        bus.out_ready = 1'b0;
        offer(64'h600, I_ADDI);
        step();
        offer(64'h604, I_ADD435);
        step();
        bus.in_valid = 1'b0;
        bus.ex_is_load = 1'b1; bus.ex_rd_wen = 1'b1; bus.ex_rd_idx = 5'd5;
        step();
        chk("rs2_hz_stall_cnt", 64'(bus.stall_cnt), 64'd2);
        chk("rs2_hz_out_pc", bus.out_pc, 64'h600);
        #2 rst = 1'b1;
        #1 chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
        chk("arst_out_pc", bus.out_pc, 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        bus.ex_is_load = 1'b0; bus.ex_rd_wen = 1'b0; bus.ex_rd_idx = '0;
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("arst_no_out1", 64'(bus.out_valid), 64'd0);
        step();
        chk("arst_no_out2", 64'(bus.out_valid), 64'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
